// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control sequencer: Moore FSM driving datapath selects and strobes,
// with a retired-instruction counter and an unsupported-encoding flag.
module mips_mc_ctrl #(
    parameter int RET_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             iord,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alu_ctrl,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic             is_lw_q, is_lw_d;
    logic [RET_W-1:0] retired_q, retired_d;

    logic pcwrite, branch, irwrite_s, memwrite_s, regwrite_s;
    logic rtype_ok;

    always_comb begin
        rtype_ok = 1'b0;
        case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: rtype_ok = 1'b1;
            default:                          rtype_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = S_FETCH;
        is_lw_d    = is_lw_q;
        retired_d  = retired_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alu_ctrl   = 3'b010;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                alusrcb   = 2'b01;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                // lw/sw choice is latched here so MEMADR need not look at op again
                is_lw_d = (op == OP_LW);
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (rtype_ok) state_d = S_EXEC;
                        else          illegal = 1'b1;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = is_lw_q ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
                retired_d  = retired_q + RET_W'(1);
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                retired_d  = retired_q + RET_W'(1);
            end
            S_EXEC: begin
                alusrca = 1'b1;
                state_d = S_ALUWB;
                case (funct)
                    F_SUB:   alu_ctrl = 3'b110;
                    F_AND:   alu_ctrl = 3'b000;
                    F_OR:    alu_ctrl = 3'b001;
                    F_SLT:   alu_ctrl = 3'b111;
                    default: alu_ctrl = 3'b010;
                endcase
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                regdst     = 1'b1;
                retired_d  = retired_q + RET_W'(1);
            end
            S_BRANCH: begin
                alusrca   = 1'b1;
                alu_ctrl  = 3'b110;
                pcsrc     = 2'b01;
                branch    = 1'b1;
                retired_d = retired_q + RET_W'(1);
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                retired_d  = retired_q + RET_W'(1);
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                pcwrite   = 1'b1;
                retired_d = retired_q + RET_W'(1);
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing writes while the FSM is held in FETCH.
    always_comb begin
        pc_en    = reset & (pcwrite | (branch & zero));
        irwrite  = reset & irwrite_s;
        memwrite = reset & memwrite_s;
        regwrite = reset & regwrite_s;
        state    = state_q;
        retired  = retired_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            is_lw_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            is_lw_q   <= is_lw_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Table-driven bench for mips_mc_ctrl with a 2-bit retired counter so wrap is exercised.
module tb_mips_mc_ctrl;

    localparam int RET_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op, funct;
    logic             zero;
    logic             pc_en, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0]       alusrcb, pcsrc;
    logic [2:0]       alu_ctrl;
    logic [3:0]       state;
    logic             illegal;
    logic [RET_W-1:0] retired;

    mips_mc_ctrl #(.RET_W(RET_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alu_ctrl(alu_ctrl), .state(state),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    // {pc_en,iord,irwrite,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alu_ctrl,illegal}
    localparam logic [15:0] E_RST    = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_FETCH  = {8'b1010_0000, 2'b01, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_DEC    = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_DECILL = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
    localparam logic [15:0] E_MEMADR = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_MEMRD  = {8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_MEMWB  = {8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_MEMWR  = {8'b0101_0000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_EX_SLT = {8'b0000_0001, 2'b00, 2'b00, 3'b111, 1'b0};
    localparam logic [15:0] E_EX_SUB = {8'b0000_0001, 2'b00, 2'b00, 3'b110, 1'b0};
    localparam logic [15:0] E_EX_AND = {8'b0000_0001, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [15:0] E_EX_OR  = {8'b0000_0001, 2'b00, 2'b00, 3'b001, 1'b0};
    localparam logic [15:0] E_ALUWB  = {8'b0000_1100, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_BR_T   = {8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam logic [15:0] E_BR_NT  = {8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
    localparam logic [15:0] E_ADDIEX = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_ADDIWB = {8'b0000_1000, 2'b00, 2'b00, 3'b010, 1'b0};
    localparam logic [15:0] E_JUMP   = {8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0};

    typedef struct {
        logic [5:0]       op;
        logic [5:0]       funct;
        logic             zero;
        logic [3:0]       st;
        logic [15:0]      ctl;
        logic [RET_W-1:0] ret;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [15:0] ctl_now();
        return {pc_en, iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, alu_ctrl, illegal};
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [3:0] s, input logic [15:0] c, input logic [RET_W-1:0] r);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.st = s; v.ctl = c; v.ret = r;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [3:0] s,
                           input logic [15:0] c, input logic [RET_W-1:0] r);
        chk({tag, "_state"},   idx, 16'(state),   16'(s));
        chk({tag, "_ctl"},     idx, ctl_now(),    c);
        chk({tag, "_retired"}, idx, 16'(retired), 16'(r));
    endtask

    initial begin
        // lw
        add(6'h23, 6'h00, 1'b0, 4'd0, E_FETCH,  2'd0);
        add(6'h23, 6'h00, 1'b0, 4'd1, E_DEC,    2'd0);
        add(6'h23, 6'h00, 1'b0, 4'd2, E_MEMADR, 2'd0);
        add(6'h23, 6'h00, 1'b0, 4'd3, E_MEMRD,  2'd0);
        add(6'h23, 6'h00, 1'b0, 4'd4, E_MEMWB,  2'd0);
        // slt
        add(6'h00, 6'h2a, 1'b0, 4'd0, E_FETCH,  2'd1);
        add(6'h00, 6'h2a, 1'b0, 4'd1, E_DEC,    2'd1);
        add(6'h00, 6'h2a, 1'b0, 4'd6, E_EX_SLT, 2'd1);
        add(6'h00, 6'h2a, 1'b0, 4'd7, E_ALUWB,  2'd1);
        // sw
        add(6'h2b, 6'h00, 1'b0, 4'd0, E_FETCH,  2'd2);
        add(6'h2b, 6'h00, 1'b0, 4'd1, E_DEC,    2'd2);
        add(6'h2b, 6'h00, 1'b0, 4'd2, E_MEMADR, 2'd2);
        add(6'h2b, 6'h00, 1'b0, 4'd5, E_MEMWR,  2'd2);
        // beq taken, then not taken (retired wraps 3 -> 0)
        add(6'h04, 6'h00, 1'b1, 4'd0, E_FETCH,  2'd3);
        add(6'h04, 6'h00, 1'b1, 4'd1, E_DEC,    2'd3);
        add(6'h04, 6'h00, 1'b1, 4'd8, E_BR_T,   2'd3);
        add(6'h04, 6'h00, 1'b0, 4'd0, E_FETCH,  2'd0);
        add(6'h04, 6'h00, 1'b0, 4'd1, E_DEC,    2'd0);
        add(6'h04, 6'h00, 1'b0, 4'd8, E_BR_NT,  2'd0);
        // illegal opcode, then illegal R-type funct
        add(6'h3f, 6'h00, 1'b0, 4'd0, E_FETCH,  2'd1);
        add(6'h3f, 6'h00, 1'b0, 4'd1, E_DECILL, 2'd1);
        add(6'h00, 6'h00, 1'b0, 4'd0, E_FETCH,  2'd1);
        add(6'h00, 6'h00, 1'b0, 4'd1, E_DECILL, 2'd1);
        // addi
        add(6'h08, 6'h00, 1'b0, 4'd0, E_FETCH,  2'd1);
        add(6'h08, 6'h00, 1'b0, 4'd1, E_DEC,    2'd1);
        add(6'h08, 6'h00, 1'b0, 4'd9, E_ADDIEX, 2'd1);
        add(6'h08, 6'h00, 1'b0, 4'd10, E_ADDIWB, 2'd1);
        // sub, and, or
        add(6'h00, 6'h22, 1'b0, 4'd0, E_FETCH,  2'd2);
        add(6'h00, 6'h22, 1'b0, 4'd1, E_DEC,    2'd2);
        add(6'h00, 6'h22, 1'b0, 4'd6, E_EX_SUB, 2'd2);
        add(6'h00, 6'h22, 1'b0, 4'd7, E_ALUWB,  2'd2);
        add(6'h00, 6'h24, 1'b0, 4'd0, E_FETCH,  2'd3);
        add(6'h00, 6'h24, 1'b0, 4'd1, E_DEC,    2'd3);
        add(6'h00, 6'h24, 1'b0, 4'd6, E_EX_AND, 2'd3);
        add(6'h00, 6'h24, 1'b0, 4'd7, E_ALUWB,  2'd3);
        add(6'h00, 6'h25, 1'b0, 4'd0, E_FETCH,  2'd0);
        add(6'h00, 6'h25, 1'b0, 4'd1, E_DEC,    2'd0);
        add(6'h00, 6'h25, 1'b0, 4'd6, E_EX_OR,  2'd0);
        add(6'h00, 6'h25, 1'b0, 4'd7, E_ALUWB,  2'd0);
        // five jumps: retired seen in each is 1,2,3,0,1
        for (int j = 0; j < 5; j++) begin
            add(6'h02, 6'h00, 1'b0, 4'd0,  E_FETCH, 2'((j + 1) % 4));
            add(6'h02, 6'h00, 1'b0, 4'd1,  E_DEC,   2'((j + 1) % 4));
            add(6'h02, 6'h00, 1'b0, 4'd11, E_JUMP,  2'((j + 1) % 4));
        end
        // lw up to MEMADR; reset is then dropped while in MEMRD
        add(6'h23, 6'h00, 1'b0, 4'd0, E_FETCH,  2'd2);
        add(6'h23, 6'h00, 1'b0, 4'd1, E_DEC,    2'd2);
        add(6'h23, 6'h00, 1'b0, 4'd2, E_MEMADR, 2'd2);

        reset = 1'b0; op = 6'h23; funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all("reset_hold", i, 4'd0, E_RST, 2'd0);
        end
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
            #1;
            chk_all("vec", i, vecs[i].st, vecs[i].ctl, vecs[i].ret);
            @(negedge clk);
        end

        chk("memrd_state", 0, 16'(state), 16'd3);
        reset = 1'b0;
        #1;
        chk_all("midrst", 0, 4'd0, E_RST, 2'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_all("midrst_hold", i, 4'd0, E_RST, 2'd0);
        end
        reset = 1'b1;
        #1;
        chk_all("post_rst", 0, 4'd0, E_FETCH, 2'd0);
        @(negedge clk);
        chk_all("post_rst", 1, 4'd1, E_DEC, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multicycle sequencer for the MIPS datapath. It replaces the single-cycle control path with a Moore FSM that reuses one ALU and one unified instruction/data memory across cycles. It takes op/funct from the instruction register plus the ALU zero flag, and drives every datapath select and write strobe each cycle. It also counts retired instructions and flags unsupported encodings.

Parameters:
RET_W, 16, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
op  in  6  inst[31:26] from instruction register
funct  in  6  inst[5:0] from instruction register
zero  in  1  ALU zero flag
pc_en  out  1  PC load enable = pcwrite | (branch & zero)
iord  out  1  memory address select: 0=PC, 1=ALUOut
irwrite  out  1  instruction register load
memwrite  out  1  data memory write strobe
regwrite  out  1  register file write strobe
regdst  out  1  write reg: 0=rt, 1=rd
memtoreg  out  1  writeback: 0=ALUOut, 1=memory data
alusrca  out  1  ALU A: 0=PC, 1=rs data
alusrcb  out  2  ALU B: 00=rt data, 01=const 4, 10=signimm, 11=signimm<<2
pcsrc  out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state  out  4  current FSM state (debug)
illegal  out  1  unsupported op/funct seen in DECODE
retired  out  RET_W  retired-instruction count

Behaviour:
- States/encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge.
- Reset (reset=0, async): state<=FETCH, retired<=0. While reset=0, pc_en, irwrite, memwrite and regwrite are forced 0. All other outputs take their FETCH values. Reset asserted mid-instruction abandons it, with no count.
- Defaults in every state: all strobes 0, selects 0, alu_ctrl=010.
- FETCH: irwrite=1, pcwrite=1, alusrca=0, alusrcb=01, pcsrc=00. Next state is DECODE.
- DECODE: alusrca=0, alusrcb=11. Transition by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> EXEC, if funct is one of 100000/100010/100100/100101/101010
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - anything else -> FETCH, with illegal=1 combinationally for this cycle only
- MEMADR: alusrca=1, alusrcb=10. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- EXEC: alusrca=1, alusrcb=00, alu_ctrl decoded from funct (add 010, sub 110, and 000, or 001, slt 111) -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, alu_ctrl=110, pcsrc=01, branch=1, so pc_en=zero -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Latency in cycles, FETCH through last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- retired: increments by 1 on each clock edge leaving MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^RET_W and never counts the illegal path.
- op/funct are sampled only in DECODE and EXEC. They are assumed stable from the FETCH edge onward; the IR holds them.

Test Plan:
- Reset held low 3 cycles, then released → state=0, retired=0, and pc_en/irwrite/memwrite/regwrite stay 0 throughout reset; first post-reset cycle shows irwrite=1, pc_en=1.
- lw (op=100011) → states 0,1,2,3,4,0; MEMRD shows iord=1; MEMWB shows regwrite=1, memtoreg=1; retired goes 0→1.
- R-type funct=101010, then sw → EXEC alu_ctrl=111 and ALUWB regdst=1, regwrite=1; sw path 0,1,2,5,0 with memwrite=1 only in state 5; retired=2.
- beq with zero=1, then beq with zero=0 → BRANCH shows pcsrc=01, alu_ctrl=110, and pc_en=1 then pc_en=0; each takes 3 cycles; retired increments on both.
- op=111111, then R-type funct=000000 → DECODE returns to FETCH with illegal=1 for exactly one cycle each time; retired unchanged.
- RET_W=2, issue 5 j instructions → retired sequence 1,2,3,0,1; each JUMP cycle shows pcsrc=10, pc_en=1; reset dropped during MEMRD → state=0 immediately, memwrite/regwrite never asserted.
